// File: rtl/pcihellocore_hexscan_if.sv
// Display bus between the hexport-side driver and the 7-segment scanner.
// The scanner takes the slave modport; the driver/bench takes the master modport.
interface pcihellocore_hexscan_if #(
   parameter int DIGITS = 8
);
   logic [31:0]       hex_in;
   logic [DIGITS-1:0] dp_in;
   logic              enable;
   logic [6:0]        seg_n;
   logic              dp_n;
   logic [DIGITS-1:0] dig_sel_n;
   logic              frame_tick;

   modport master (
      output hex_in, dp_in, enable,
      input  seg_n, dp_n, dig_sel_n, frame_tick
   );

   modport slave (
      input  hex_in, dp_in, enable,
      output seg_n, dp_n, dig_sel_n, frame_tick
   );
endinterface

// File: rtl/pcihellocore_hexscan.sv
// Time-multiplexed common-anode 7-segment scanner with per-frame snapshot,
// anti-ghost blank slot between digits and optional leading-zero blanking.
module pcihellocore_hexscan #(
   parameter int DIGITS       = 8,
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 16,
   parameter bit LZ_BLANK     = 1'b0
) (
   input logic                   clk,
   input logic                   reset_n,
   pcihellocore_hexscan_if.slave port
);
   localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int HEX_W = 4 * DIGITS;

   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

   typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [IDX_W-1:0]  idx, idx_nx;
   logic [HEX_W-1:0]  hex_sh, hex_sh_nx;
   logic [DIGITS-1:0] dp_sh, dp_sh_nx;

   logic [6:0]        seg_q, seg_nx;
   logic              dp_q, dp_nx;
   logic [DIGITS-1:0] sel_q, sel_nx;
   logic              tick_q, tick_nx;

   logic [3:0]        nib;
   logic              run_zero;
   logic              lz_sel;
   logic              dp_sel;

   function automatic logic [6:0] font(input logic [3:0] n);
      case (n)
         4'h0: return 7'h3F;
         4'h1: return 7'h06;
         4'h2: return 7'h5B;
         4'h3: return 7'h4F;
         4'h4: return 7'h66;
         4'h5: return 7'h6D;
         4'h6: return 7'h7D;
         4'h7: return 7'h07;
         4'h8: return 7'h7F;
         4'h9: return 7'h6F;
         4'hA: return 7'h77;
         4'hB: return 7'h7C;
         4'hC: return 7'h39;
         4'hD: return 7'h5E;
         4'hE: return 7'h79;
         default: return 7'h71;
      endcase
   endfunction

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      idx_nx    = idx;
      hex_sh_nx = hex_sh;
      dp_sh_nx  = dp_sh;
      tick_nx   = 1'b0;

      if (!port.enable) begin
         state_nx = IDLE;
         cnt_nx   = '0;
         idx_nx   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nx  = BLANK;
               cnt_nx    = '0;
               idx_nx    = '0;
               hex_sh_nx = port.hex_in[HEX_W-1:0];
               dp_sh_nx  = port.dp_in;
            end
            BLANK: begin
               cnt_nx = cnt + 1'b1;
               if (cnt == BLANK_LAST) state_nx = DRIVE;
            end
            DRIVE: begin
               if (cnt == CNT_LAST) begin
                  cnt_nx   = '0;
                  state_nx = BLANK;
                  // End of the last digit closes the frame: resample and pulse.
                  if (idx == IDX_LAST) begin
                     idx_nx    = '0;
                     hex_sh_nx = port.hex_in[HEX_W-1:0];
                     dp_sh_nx  = port.dp_in;
                     tick_nx   = 1'b1;
                  end else begin
                     idx_nx = idx + 1'b1;
                  end
               end else begin
                  cnt_nx = cnt + 1'b1;
               end
            end
            default: state_nx = IDLE;
         endcase
      end

      // Walk from the top digit down so run_zero means "this and all higher nibbles are 0".
      nib      = 4'h0;
      run_zero = 1'b1;
      lz_sel   = 1'b0;
      dp_sel   = 1'b0;
      sel_nx   = '1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         run_zero = run_zero & (hex_sh[4*i +: 4] == 4'h0);
         if (idx_nx == IDX_W'(i)) begin
            nib    = hex_sh[4*i +: 4];
            lz_sel = run_zero && (i != 0);
            dp_sel = dp_sh[i];
            if (state_nx == DRIVE) sel_nx[i] = 1'b0;
         end
      end

      seg_nx = 7'h7F;
      dp_nx  = 1'b1;
      if (state_nx == DRIVE) begin
         seg_nx = (LZ_BLANK && lz_sel) ? 7'h7F : ~font(nib);
         dp_nx  = ~dp_sel;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         cnt    <= '0;
         idx    <= '0;
         hex_sh <= '0;
         dp_sh  <= '0;
         seg_q  <= 7'h7F;
         dp_q   <= 1'b1;
         sel_q  <= '1;
         tick_q <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         idx    <= idx_nx;
         hex_sh <= hex_sh_nx;
         dp_sh  <= dp_sh_nx;
         seg_q  <= seg_nx;
         dp_q   <= dp_nx;
         sel_q  <= sel_nx;
         tick_q <= tick_nx;
      end
   end

   assign port.seg_n      = seg_q;
   assign port.dp_n       = dp_q;
   assign port.dig_sel_n  = sel_q;
   assign port.frame_tick = tick_q;
endmodule

// File: tb/tb_pcihellocore_hexscan.sv
// Directed bench for the 7-segment scanner: one plain and one leading-zero-blanking
// instance, PRESCALE=8, BLANK_CYCLES=2, DIGITS=8.
module tb_pcihellocore_hexscan;
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   pcihellocore_hexscan_if #(.DIGITS(8)) bus0 ();
   pcihellocore_hexscan_if #(.DIGITS(8)) bus1 ();

   pcihellocore_hexscan #(.DIGITS(8), .PRESCALE(8), .BLANK_CYCLES(2), .LZ_BLANK(1'b0)) dut (
      .clk(clk), .reset_n(reset_n), .port(bus0)
   );
   pcihellocore_hexscan #(.DIGITS(8), .PRESCALE(8), .BLANK_CYCLES(2), .LZ_BLANK(1'b1)) dut_lz (
      .clk(clk), .reset_n(reset_n), .port(bus1)
   );

   typedef struct packed {
      logic        lz;
      logic [31:0] hex;
      logic [7:0]  dp;
      logic [2:0]  digit;
      logic [6:0]  seg;
      logic        dpn;
   } vec_t;

   localparam int NVEC = 25;
   localparam logic [16:0] DARK = 17'h0FFFF;

   vec_t vecs [NVEC];
   int n_cmp = 0;
   int n_fail = 0;
   int kc = 0;

   // {frame_tick, dig_sel_n, dp_n, seg_n}
   function automatic logic [16:0] obs(input bit lz);
      if (lz) return {bus1.frame_tick, bus1.dig_sel_n, bus1.dp_n, bus1.seg_n};
      return {bus0.frame_tick, bus0.dig_sel_n, bus0.dp_n, bus0.seg_n};
   endfunction

   function automatic logic [16:0] exp_digit(input int d, input logic dpn, input logic [6:0] seg);
      logic [7:0] s;
      s = 8'h01 << d;
      return {1'b0, ~s, dpn, seg};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (k=%0d)", name, act, exp, kc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      kc++;
   endtask

   task automatic set_in(input logic [31:0] hex, input logic [7:0] dp, input logic en);
      bus0.hex_in = hex; bus0.dp_in = dp; bus0.enable = en;
      bus1.hex_in = hex; bus1.dp_in = dp; bus1.enable = en;
   endtask

   // Returns just after the edge that leaves IDLE; kc=0 is the first blank cycle.
   task automatic start_scan(input logic [31:0] hex, input logic [7:0] dp);
      set_in(hex, dp, 1'b0);
      tick();
      set_in(hex, dp, 1'b1);
      tick();
      kc = 0;
   endtask

   task automatic advance_to(input int k);
      while (kc < k) tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int first, second;

      vecs[0]  = '{1'b0, 32'h12345678, 8'h00, 3'd0, 7'h00, 1'b1};
      vecs[1]  = '{1'b0, 32'h12345678, 8'h00, 3'd1, 7'h78, 1'b1};
      vecs[2]  = '{1'b0, 32'h12345678, 8'h00, 3'd4, 7'h19, 1'b1};
      vecs[3]  = '{1'b0, 32'h12345678, 8'h00, 3'd7, 7'h79, 1'b1};
      vecs[4]  = '{1'b0, 32'h89ABCDEF, 8'h01, 3'd0, 7'h0E, 1'b0};
      vecs[5]  = '{1'b0, 32'h89ABCDEF, 8'h01, 3'd2, 7'h21, 1'b1};
      vecs[6]  = '{1'b0, 32'h89ABCDEF, 8'h01, 3'd5, 7'h08, 1'b1};
      vecs[7]  = '{1'b0, 32'h00000000, 8'h80, 3'd7, 7'h40, 1'b0};
      vecs[8]  = '{1'b0, 32'hC9B6E320, 8'h00, 3'd1, 7'h24, 1'b1};
      vecs[9]  = '{1'b0, 32'hC9B6E320, 8'h00, 3'd2, 7'h30, 1'b1};
      vecs[10] = '{1'b0, 32'hC9B6E320, 8'h00, 3'd3, 7'h06, 1'b1};
      vecs[11] = '{1'b0, 32'hC9B6E320, 8'h00, 3'd4, 7'h02, 1'b1};
      vecs[12] = '{1'b0, 32'hC9B6E320, 8'h00, 3'd5, 7'h03, 1'b1};
      vecs[13] = '{1'b0, 32'hC9B6E320, 8'h00, 3'd6, 7'h10, 1'b1};
      vecs[14] = '{1'b0, 32'hC9B6E320, 8'h00, 3'd7, 7'h46, 1'b1};
      vecs[15] = '{1'b1, 32'h00000A05, 8'h00, 3'd0, 7'h12, 1'b1};
      vecs[16] = '{1'b1, 32'h00000A05, 8'h00, 3'd1, 7'h40, 1'b1};
      vecs[17] = '{1'b1, 32'h00000A05, 8'h00, 3'd2, 7'h08, 1'b1};
      vecs[18] = '{1'b1, 32'h00000A05, 8'h00, 3'd3, 7'h7F, 1'b1};
      vecs[19] = '{1'b1, 32'h00000A05, 8'h00, 3'd7, 7'h7F, 1'b1};
      vecs[20] = '{1'b1, 32'h00000000, 8'h10, 3'd4, 7'h7F, 1'b0};
      vecs[21] = '{1'b1, 32'h00000000, 8'h00, 3'd0, 7'h40, 1'b1};
      vecs[22] = '{1'b1, 32'h80000000, 8'h00, 3'd6, 7'h40, 1'b1};
      vecs[23] = '{1'b1, 32'h80000000, 8'h00, 3'd7, 7'h00, 1'b1};
      vecs[24] = '{1'b0, 32'h00000A05, 8'h00, 3'd3, 7'h40, 1'b1};

      // Reset and idle with enable low
      reset_n = 1'b0;
      set_in(32'h0, 8'h0, 1'b0);
      repeat (3) tick();
      check("reset_dut", {15'h0, obs(1'b0)}, {15'h0, DARK});
      check("reset_lz", {15'h0, obs(1'b1)}, {15'h0, DARK});
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check($sformatf("idle_%0d", i), {15'h0, obs(1'b0)}, {15'h0, DARK});
      end

      // Slot timing of the first two digits, then frame_tick period
      start_scan(32'h12345678, 8'h00);
      for (int k = 0; k < 12; k++) begin
         logic [16:0] e;
         advance_to(k);
         if (k < 2 || k == 8 || k == 9) e = DARK;
         else if (k < 8) e = exp_digit(0, 1'b1, 7'h00);
         else e = exp_digit(1, 1'b1, 7'h78);
         check($sformatf("timing_k%0d", k), {15'h0, obs(1'b0)}, {15'h0, e});
      end
      first = 0;
      second = 0;
      while (kc < 140) begin
         tick();
         if (bus0.frame_tick === 1'b1) begin
            if (first == 0) first = kc;
            else if (second == 0) second = kc;
         end
      end
      check("tick_first", first, 64);
      check("tick_second", second, 128);

      // Table-driven digit contents, first and last drive cycle of the slot
      for (int i = 0; i < NVEC; i++) begin
         v = vecs[i];
         start_scan(v.hex, v.dp);
         advance_to(8 * int'(v.digit) + 2);
         check($sformatf("vec%0d_first", i), {15'h0, obs(v.lz)},
               {15'h0, exp_digit(int'(v.digit), v.dpn, v.seg)});
         advance_to(8 * int'(v.digit) + 7);
         check($sformatf("vec%0d_last", i), {15'h0, obs(v.lz)},
               {15'h0, exp_digit(int'(v.digit), v.dpn, v.seg)});
      end

      // Mid-frame input change becomes visible only on the next frame
      start_scan(32'h12345678, 8'h00);
      advance_to(27);
      set_in(32'hFFFFFFFF, 8'h00, 1'b1);
      advance_to(34);
      check("coh_d4_old", {15'h0, obs(1'b0)}, {15'h0, exp_digit(4, 1'b1, 7'h19)});
      advance_to(58);
      check("coh_d7_old", {15'h0, obs(1'b0)}, {15'h0, exp_digit(7, 1'b1, 7'h79)});
      advance_to(66);
      check("coh_d0_new", {15'h0, obs(1'b0)}, {15'h0, exp_digit(0, 1'b1, 7'h0E)});
      advance_to(106);
      check("coh_d5_new", {15'h0, obs(1'b0)}, {15'h0, exp_digit(5, 1'b1, 7'h0E)});

      // Enable dropped mid-DRIVE of digit 5, then re-enabled with a new value
      start_scan(32'h12345678, 8'h00);
      advance_to(44);
      check("en_d5", {15'h0, obs(1'b0)}, {15'h0, exp_digit(5, 1'b1, 7'h30)});
      set_in(32'h12345678, 8'h00, 1'b0);
      tick();
      check("en_off_dark", {15'h0, obs(1'b0)}, {15'h0, DARK});
      set_in(32'h89ABCDEF, 8'h00, 1'b1);
      tick();
      check("en_re_blank0", {15'h0, obs(1'b0)}, {15'h0, DARK});
      tick();
      check("en_re_blank1", {15'h0, obs(1'b0)}, {15'h0, DARK});
      tick();
      check("en_re_d0", {15'h0, obs(1'b0)}, {15'h0, exp_digit(0, 1'b1, 7'h0E)});

      // Asynchronous reset mid-DRIVE
      start_scan(32'h12345678, 8'h00);
      advance_to(4);
      check("ar_before", {15'h0, obs(1'b0)}, {15'h0, exp_digit(0, 1'b1, 7'h00)});
      #3;
      reset_n = 1'b0;
      #1;
      check("ar_dark", {15'h0, obs(1'b0)}, {15'h0, DARK});
      check("ar_dark_lz", {15'h0, obs(1'b1)}, {15'h0, DARK});
      set_in(32'h00000A05, 8'h00, 1'b0);
      repeat (3) tick();
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("ar_idle_%0d", i), {15'h0, obs(1'b0)}, {15'h0, DARK});
      end
      start_scan(32'h00000A05, 8'h00);
      advance_to(2);
      check("ar_restart_lz", {15'h0, obs(1'b1)}, {15'h0, exp_digit(0, 1'b1, 7'h12)});

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end
endmodule
